// File: rtl/fetch_unit.sv
// fetch_unit: AXI burst instruction fetch feeding a 2-in/1-out instruction FIFO.
// Optional macro FETCH_TRACE_EN prints pops and redirects in simulation.

module fetch_unit #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] entry,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [ADDR_WIDTH-1:0] beat_q, beat_d;
  logic                  kill_q, kill_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic [31:0]           mem_inst [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
  logic                  mem_err  [DEPTH];

  logic                  push_lo, push_hi, flush;
  logic                  pop, beat_fire, space_ok;
  logic [1:0]            n_push;
  logic [CW-1:0]         free_cnt;
  logic [ADDR_WIDTH-1:0] line_base, beat_hi_pc;
  logic                  we0, we1;
  logic [AW-1:0]         idx0, idx1;
  logic [31:0]           data0;
  logic [ADDR_WIDTH-1:0] pc0;
  logic                  beat_err;
  logic                  unused_rid;

  assign unused_rid = ^m_axi_rid;

  assign m_axi_arid    = '0;
  assign m_axi_arlen   = 8'd7;
  assign m_axi_arsize  = 3'd3;
  assign m_axi_arburst = 2'd1;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'h6;
  assign m_axi_araddr  = araddr_q;

  assign line_base  = {fetch_pc_q[ADDR_WIDTH-1:6], 6'd0};
  assign free_cnt   = CW'(DEPTH) - count_q;
  assign space_ok   = free_cnt >= CW'(16);
  assign beat_fire  = m_axi_rvalid && m_axi_rready;
  assign beat_hi_pc = beat_q + ADDR_WIDTH'(4);
  assign beat_err   = m_axi_rresp != 2'd0;

  assign inst_valid = count_q != '0;
  assign pop        = inst_valid && inst_ready;
  assign inst       = inst_valid ? mem_inst[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr_q] : '0;
  assign inst_err   = inst_valid ? mem_err[rd_ptr_q] : 1'b0;

  // fetch FSM: burst issue, beat filtering, redirect handling
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    araddr_d      = araddr_q;
    beat_d        = beat_q;
    kill_d        = kill_q;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    push_lo       = 1'b0;
    push_hi       = 1'b0;
    flush         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          araddr_d   = {redirect_pc[ADDR_WIDTH-1:6], 6'd0};
          kill_d     = 1'b0;
          state_d    = S_ADDR;
        end else if (space_ok) begin
          araddr_d = line_base;
          kill_d   = 1'b0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          kill_d     = 1'b1;
        end
        if (m_axi_arready) begin
          beat_d  = araddr_q;
          state_d = (kill_q || redirect_valid) ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        m_axi_rready = 1'b1;
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          state_d    = (beat_fire && m_axi_rlast) ? S_IDLE : S_DRAIN;
        end else if (beat_fire) begin
          beat_d = beat_q + ADDR_WIDTH'(8);
          if (beat_hi_pc < fetch_pc_q) begin
            push_hi = 1'b0;
          end else if (beat_q < fetch_pc_q) begin
            push_hi = 1'b1;
          end else begin
            push_lo = 1'b1;
            push_hi = 1'b1;
          end
          if (m_axi_rlast) begin
            fetch_pc_d = araddr_q + ADDR_WIDTH'(64);
            state_d    = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        m_axi_rready = 1'b1;
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end
        if (beat_fire && m_axi_rlast) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping: up to two pushes and one pop per cycle, flush wins
  always_comb begin
    n_push = {1'b0, push_lo} + {1'b0, push_hi};
    we0    = push_lo || push_hi;
    we1    = push_lo && push_hi;
    idx0   = wr_ptr_q;
    idx1   = wr_ptr_q + AW'(1);
    data0  = push_lo ? m_axi_rdata[31:0] : m_axi_rdata[63:32];
    pc0    = push_lo ? beat_q : beat_hi_pc;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(n_push);
      count_d  = count_q + CW'(n_push) - CW'(pop);
    end
  end

  // control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= entry;
      araddr_q   <= '0;
      beat_q     <= '0;
      kill_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      araddr_q   <= araddr_d;
      beat_q     <= beat_d;
      kill_q     <= kill_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents only matter behind count_q
  always_ff @(posedge clk) begin
    if (we0) begin
      mem_inst[idx0] <= data0;
      mem_pc[idx0]   <= pc0;
      mem_err[idx0]  <= beat_err;
    end
    if (we1) begin
      mem_inst[idx1] <= m_axi_rdata[63:32];
      mem_pc[idx1]   <= beat_hi_pc;
      mem_err[idx1]  <= beat_err;
    end
  end

`ifdef FETCH_TRACE_EN
  // simulation trace of consumed instructions and redirects
  always @(posedge clk) begin
    if (reset_n && pop && !redirect_valid)
      $display("FETCH pc=%h inst=%h", inst_pc, inst);
    if (reset_n && redirect_valid)
      $display("REDIRECT %h", redirect_pc);
  end
`else
`endif

endmodule
